accelerator_softmax_arbiter: RTL and testbench

Round-robin arbiter and sequencer sharing one `accelerator_vector_softmax` engine between `REQUESTERS` NTM clients, for example read/write heads that each need a softmax over an addressing vector. It grants the engine to one requester per transaction and pulses the engine `START`. It then forwards the granted requester's size, length and data stream to the engine, returns the results to that requester, and releases the grant on engine `READY`.

---
 rtl/accelerator_softmax_arbiter_pkg.sv | 11 +
 rtl/accelerator_round_robin_picker.sv | 32 +++
 rtl/accelerator_softmax_arbiter.sv | 175 +++++++++++++++++
 tb/tb_accelerator_softmax_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/accelerator_softmax_arbiter_pkg.sv
// accelerator_softmax_arbiter_pkg: shared FSM state type and bit constants for the softmax arbiter
package accelerator_softmax_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE_STATE,
    START_STATE,
    STREAM_STATE,
    RELEASE_STATE
  } state_t;
  localparam logic ZERO = 1'b0;
  localparam logic ONE = 1'b1;
endpackage

// File: rtl/accelerator_round_robin_picker.sv
// accelerator_round_robin_picker: combinational round-robin winner search starting after the last grant
//   req_i     : request vector, one bit per client
//   ptr_i     : index of the previous winner
//   winner_o  : first requesting index after ptr_i, with wrap-around
//   valid_o   : high when any request is set
module accelerator_round_robin_picker
  import accelerator_softmax_arbiter_pkg::*;
#(
  parameter int REQUESTERS = 4,
  parameter int IW = $clog2(REQUESTERS)
) (
  input  logic [REQUESTERS-1:0] req_i,
  input  logic [IW-1:0]         ptr_i,
  output logic [IW-1:0]         winner_o,
  output logic                  valid_o
);
  logic [IW:0] k;
  // Scan from farthest to nearest so the nearest requester after ptr_i is written last and wins.
  always_comb begin
    winner_o = '0;
    valid_o = ZERO;
    k = '0;
    for (int i = REQUESTERS; i >= 1; i--) begin
      k = {1'b0, ptr_i} + (IW+1)'(i);
      k = k >= (IW+1)'(REQUESTERS) ? k - (IW+1)'(REQUESTERS) : k;
      if (req_i[k[IW-1:0]]) begin
        winner_o = k[IW-1:0];
        valid_o = ONE;
      end
    end
  end
endmodule

// File: rtl/accelerator_softmax_arbiter.sv
// accelerator_softmax_arbiter: round-robin sharing of one softmax engine among REQUESTERS clients
//   CLK/RST                      : clock, asynchronous active-high reset
//   REQ/GRANT/DONE               : per-client request level, owner grant, end-of-transaction pulse
//   ERROR                        : watchdog abort pulse (only with ACCELERATOR_SOFTMAX_ARBITER_TIMEOUT_EN)
//   SIZE_IN/LENGTH_IN/DATA_IN    : packed per-client operands, client k in slice k
//   DATA_IN_*_ENABLE             : per-client input strobes
//   DATA_OUT/DATA_OUT_*_ENABLE   : broadcast result word, owner-only result strobes
//   ENGINE_*                     : engine control and registered data path
// Optional macro ACCELERATOR_SOFTMAX_ARBITER_TIMEOUT_EN adds a TIMEOUT_CYCLES streaming watchdog.
module accelerator_softmax_arbiter
  import accelerator_softmax_arbiter_pkg::*;
#(
  parameter int DATA_SIZE = 64,
  parameter int CONTROL_SIZE = 4,
  parameter int REQUESTERS = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [REQUESTERS-1:0]           REQ,
  output logic [REQUESTERS-1:0]           GRANT,
  output logic [REQUESTERS-1:0]           DONE,
  output logic                            ERROR,
  input  logic [REQUESTERS*DATA_SIZE-1:0] SIZE_IN,
  input  logic [REQUESTERS*DATA_SIZE-1:0] LENGTH_IN,
  input  logic [REQUESTERS*DATA_SIZE-1:0] DATA_IN,
  input  logic [REQUESTERS-1:0]           DATA_IN_VECTOR_ENABLE,
  input  logic [REQUESTERS-1:0]           DATA_IN_SCALAR_ENABLE,
  output logic [DATA_SIZE-1:0]            DATA_OUT,
  output logic [REQUESTERS-1:0]           DATA_OUT_VECTOR_ENABLE,
  output logic [REQUESTERS-1:0]           DATA_OUT_SCALAR_ENABLE,
  output logic                            ENGINE_START,
  input  logic                            ENGINE_READY,
  output logic                            ENGINE_DATA_IN_VECTOR_ENABLE,
  output logic                            ENGINE_DATA_IN_SCALAR_ENABLE,
  output logic [DATA_SIZE-1:0]            ENGINE_SIZE_IN,
  output logic [DATA_SIZE-1:0]            ENGINE_LENGTH_IN,
  output logic [DATA_SIZE-1:0]            ENGINE_DATA_IN,
  input  logic                            ENGINE_DATA_OUT_VECTOR_ENABLE,
  input  logic                            ENGINE_DATA_OUT_SCALAR_ENABLE,
  input  logic [DATA_SIZE-1:0]            ENGINE_DATA_OUT
);
  localparam int IW = $clog2(REQUESTERS);
  if (REQUESTERS < 2 || CONTROL_SIZE < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("accelerator_softmax_arbiter: invalid parameters");
  end
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, win_q, win_d, pick;
  logic pick_valid, timeout;
  logic [REQUESTERS-1:0] grant_q, grant_d, done_q, done_d, dov_q, dov_d, dos_q, dos_d;
  logic start_q, start_d, eiv_q, eiv_d, eis_q, eis_d;
  logic [DATA_SIZE-1:0] esize_q, esize_d, elen_q, elen_d, edata_q, edata_d, dout_q, dout_d;
  logic [DATA_SIZE-1:0] size_a [REQUESTERS];
  logic [DATA_SIZE-1:0] len_a [REQUESTERS];
  logic [DATA_SIZE-1:0] data_a [REQUESTERS];
  for (genvar g = 0; g < REQUESTERS; g++) begin : g_slice
    assign size_a[g] = SIZE_IN[g*DATA_SIZE +: DATA_SIZE];
    assign len_a[g] = LENGTH_IN[g*DATA_SIZE +: DATA_SIZE];
    assign data_a[g] = DATA_IN[g*DATA_SIZE +: DATA_SIZE];
  end
  accelerator_round_robin_picker #(.REQUESTERS(REQUESTERS), .IW(IW)) u_picker (
    .req_i(REQ),
    .ptr_i(ptr_q),
    .winner_o(pick),
    .valid_o(pick_valid)
  );
`ifdef ACCELERATOR_SOFTMAX_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  logic error_q, error_d;
  // The counter only advances on cycles without READY, so reaching TIMEOUT_CYCLES in RELEASE means abort.
  assign cnt_d = state_q == STREAM_STATE ? cnt_q + TW'(!ENGINE_READY) : '0;
  assign timeout = state_q == STREAM_STATE && !ENGINE_READY && cnt_q == TW'(TIMEOUT_CYCLES - 1);
  assign error_d = state_q == RELEASE_STATE && cnt_q == TW'(TIMEOUT_CYCLES);
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      cnt_q <= '0;
      error_q <= ZERO;
    end else begin
      cnt_q <= cnt_d;
      error_q <= error_d;
    end
  assign ERROR = error_q;
`else
  assign timeout = ZERO;
  assign ERROR = ZERO;
`endif
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    win_d = win_q;
    grant_d = grant_q;
    esize_d = esize_q;
    elen_d = elen_q;
    edata_d = edata_q;
    dout_d = dout_q;
    done_d = '0;
    dov_d = '0;
    dos_d = '0;
    start_d = ZERO;
    eiv_d = ZERO;
    eis_d = ZERO;
    case (state_q)
      IDLE_STATE: if (pick_valid) begin
        win_d = pick;
        esize_d = size_a[pick];
        elen_d = len_a[pick];
        state_d = START_STATE;
      end
      START_STATE: begin
        grant_d = REQUESTERS'(1) << win_q;
        start_d = ONE;
        state_d = STREAM_STATE;
      end
      STREAM_STATE: begin
        edata_d = data_a[win_q];
        eiv_d = DATA_IN_VECTOR_ENABLE[win_q];
        eis_d = DATA_IN_SCALAR_ENABLE[win_q];
        dov_d[win_q] = ENGINE_DATA_OUT_VECTOR_ENABLE;
        dos_d[win_q] = ENGINE_DATA_OUT_SCALAR_ENABLE;
        dout_d = ENGINE_DATA_OUT;
        state_d = ENGINE_READY || timeout ? RELEASE_STATE : STREAM_STATE;
      end
      default: begin
        grant_d = '0;
        done_d = REQUESTERS'(1) << win_q;
        ptr_d = win_q;
        state_d = IDLE_STATE;
      end
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE_STATE;
      ptr_q <= IW'(REQUESTERS - 1);
      win_q <= '0;
      grant_q <= '0;
      done_q <= '0;
      dov_q <= '0;
      dos_q <= '0;
      start_q <= ZERO;
      eiv_q <= ZERO;
      eis_q <= ZERO;
      esize_q <= '0;
      elen_q <= '0;
      edata_q <= '0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
      grant_q <= grant_d;
      done_q <= done_d;
      dov_q <= dov_d;
      dos_q <= dos_d;
      start_q <= start_d;
      eiv_q <= eiv_d;
      eis_q <= eis_d;
      esize_q <= esize_d;
      elen_q <= elen_d;
      edata_q <= edata_d;
      dout_q <= dout_d;
    end
  assign GRANT = grant_q;
  assign DONE = done_q;
  assign DATA_OUT = dout_q;
  assign DATA_OUT_VECTOR_ENABLE = dov_q;
  assign DATA_OUT_SCALAR_ENABLE = dos_q;
  assign ENGINE_START = start_q;
  assign ENGINE_DATA_IN_VECTOR_ENABLE = eiv_q;
  assign ENGINE_DATA_IN_SCALAR_ENABLE = eis_q;
  assign ENGINE_SIZE_IN = esize_q;
  assign ENGINE_LENGTH_IN = elen_q;
  assign ENGINE_DATA_IN = edata_q;
endmodule

// File: tb/tb_accelerator_softmax_arbiter.sv
// tb_accelerator_softmax_arbiter: directed table-driven bench for accelerator_softmax_arbiter
module tb_accelerator_softmax_arbiter;
  localparam int DW = 64;
  localparam int N = 4;
  logic CLK = 1'b0;
  logic RST;
  logic [N-1:0] REQ, GRANT, DONE, DATA_IN_VECTOR_ENABLE, DATA_IN_SCALAR_ENABLE;
  logic [N-1:0] DATA_OUT_VECTOR_ENABLE, DATA_OUT_SCALAR_ENABLE;
  logic ERROR, ENGINE_START, ENGINE_READY, ENGINE_DATA_IN_VECTOR_ENABLE, ENGINE_DATA_IN_SCALAR_ENABLE;
  logic ENGINE_DATA_OUT_VECTOR_ENABLE, ENGINE_DATA_OUT_SCALAR_ENABLE;
  logic [N*DW-1:0] SIZE_IN, LENGTH_IN, DATA_IN;
  logic [DW-1:0] DATA_OUT, ENGINE_SIZE_IN, ENGINE_LENGTH_IN, ENGINE_DATA_IN, ENGINE_DATA_OUT;
  int n_vec = 0;
  int n_bad = 0;
  typedef struct {
    logic [N-1:0] req;
    int win;
  } vec_t;
  vec_t tbl[12];

  accelerator_softmax_arbiter #(.DATA_SIZE(DW), .CONTROL_SIZE(4), .REQUESTERS(N), .TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .GRANT(GRANT), .DONE(DONE), .ERROR(ERROR),
    .SIZE_IN(SIZE_IN), .LENGTH_IN(LENGTH_IN), .DATA_IN(DATA_IN),
    .DATA_IN_VECTOR_ENABLE(DATA_IN_VECTOR_ENABLE), .DATA_IN_SCALAR_ENABLE(DATA_IN_SCALAR_ENABLE),
    .DATA_OUT(DATA_OUT), .DATA_OUT_VECTOR_ENABLE(DATA_OUT_VECTOR_ENABLE),
    .DATA_OUT_SCALAR_ENABLE(DATA_OUT_SCALAR_ENABLE),
    .ENGINE_START(ENGINE_START), .ENGINE_READY(ENGINE_READY),
    .ENGINE_DATA_IN_VECTOR_ENABLE(ENGINE_DATA_IN_VECTOR_ENABLE),
    .ENGINE_DATA_IN_SCALAR_ENABLE(ENGINE_DATA_IN_SCALAR_ENABLE),
    .ENGINE_SIZE_IN(ENGINE_SIZE_IN), .ENGINE_LENGTH_IN(ENGINE_LENGTH_IN), .ENGINE_DATA_IN(ENGINE_DATA_IN),
    .ENGINE_DATA_OUT_VECTOR_ENABLE(ENGINE_DATA_OUT_VECTOR_ENABLE),
    .ENGINE_DATA_OUT_SCALAR_ENABLE(ENGINE_DATA_OUT_SCALAR_ENABLE),
    .ENGINE_DATA_OUT(ENGINE_DATA_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    REQ = '0;
    DATA_IN = '0;
    DATA_IN_VECTOR_ENABLE = '0;
    DATA_IN_SCALAR_ENABLE = '0;
    ENGINE_READY = 1'b0;
    ENGINE_DATA_OUT_VECTOR_ENABLE = 1'b0;
    ENGINE_DATA_OUT_SCALAR_ENABLE = 1'b0;
    ENGINE_DATA_OUT = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, 64'({GRANT, DONE, DATA_OUT_VECTOR_ENABLE, DATA_OUT_SCALAR_ENABLE, ERROR,
                               ENGINE_START, ENGINE_DATA_IN_VECTOR_ENABLE, ENGINE_DATA_IN_SCALAR_ENABLE}), 64'd0);
    check({name, "_data"}, DATA_OUT | ENGINE_SIZE_IN | ENGINE_LENGTH_IN | ENGINE_DATA_IN, 64'd0);
  endtask

  // One full transaction: REQ seen at edge t, grant/start after t+1, READY sampled at r, DONE after r+1.
  task automatic run_txn(input logic [N-1:0] req, input int win, input int wait_cycles);
    logic [N-1:0] g;
    g = 4'(1) << win;
    REQ = req;
    tick();
    check($sformatf("t%0d_grant_before", win), GRANT, 64'd0);
    tick();
    check($sformatf("t%0d_grant", win), GRANT, g);
    check($sformatf("t%0d_start", win), ENGINE_START, 64'd1);
    check($sformatf("t%0d_size", win), ENGINE_SIZE_IN, 64'(16 + win));
    check($sformatf("t%0d_length", win), ENGINE_LENGTH_IN, 64'(32 + win));
    tick();
    check($sformatf("t%0d_start_low", win), ENGINE_START, 64'd0);
    repeat (wait_cycles) tick();
    ENGINE_READY = 1'b1;
    tick();
    ENGINE_READY = 1'b0;
    check($sformatf("t%0d_grant_held", win), {DONE, GRANT}, {4'b0, g});
    tick();
    check($sformatf("t%0d_done", win), {DONE, GRANT}, {g, 4'b0});
  endtask

  initial begin
    int bad_g;
    RST = 1'b1;
    clear_inputs();
    for (int k = 0; k < N; k++) begin
      SIZE_IN[k*DW +: DW] = 64'(16 + k);
      LENGTH_IN[k*DW +: DW] = 64'(32 + k);
    end
    tbl[0] = '{4'b1111, 0};
    tbl[1] = '{4'b1111, 1};
    tbl[2] = '{4'b1111, 2};
    tbl[3] = '{4'b1111, 3};
    tbl[4] = '{4'b1111, 0};
    tbl[5] = '{4'b0011, 1};
    tbl[6] = '{4'b0011, 0};
    tbl[7] = '{4'b1100, 2};
    tbl[8] = '{4'b0101, 0};
    tbl[9] = '{4'b1010, 1};
    tbl[10] = '{4'b1010, 3};
    tbl[11] = '{4'b0110, 1};
    #3;
    check_all_zero("reset");
    tick();
    RST = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) run_txn(tbl[i].req, tbl[i].win, i % 3);
    REQ = '0;
    tick();

    // Client 2 streams 4 words; client 3 strobes are noise; READY in START is ignored; client 0 waits.
    do_reset();
    REQ = 4'b0100;
    tick();
    ENGINE_READY = 1'b1;
    tick();
    ENGINE_READY = 1'b0;
    check("b_grant", GRANT, 64'b0100);
    check("b_start", ENGINE_START, 64'd1);
    REQ = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      DATA_IN[2*DW +: DW] = 64'hA0 + 64'(i);
      DATA_IN[3*DW +: DW] = '1;
      DATA_IN_VECTOR_ENABLE = 4'b1100;
      DATA_IN_SCALAR_ENABLE = 4'b1000;
      ENGINE_DATA_OUT = 64'hB0 + 64'(i);
      ENGINE_DATA_OUT_SCALAR_ENABLE = 1'b1;
      #1;
      if (i == 0) check("b_no_comb_path", ENGINE_DATA_IN_VECTOR_ENABLE, 64'd0);
      tick();
      check($sformatf("b_eng_vec%0d", i), ENGINE_DATA_IN_VECTOR_ENABLE, 64'd1);
      check($sformatf("b_eng_data%0d", i), ENGINE_DATA_IN, 64'hA0 + 64'(i));
      check($sformatf("b_eng_scalar%0d", i), ENGINE_DATA_IN_SCALAR_ENABLE, 64'd0);
      check($sformatf("b_out_str%0d", i), {DATA_OUT_VECTOR_ENABLE, DATA_OUT_SCALAR_ENABLE}, 64'b0000_0100);
      check($sformatf("b_out_data%0d", i), DATA_OUT, 64'hB0 + 64'(i));
      if (i == 0) check("b_early_done", {DONE, ENGINE_START}, 64'd0);
    end
    DATA_IN_VECTOR_ENABLE = 4'b1000;
    ENGINE_DATA_OUT_SCALAR_ENABLE = 1'b0;
    #1;
    check("b_strobe_held", ENGINE_DATA_IN_VECTOR_ENABLE, 64'd1);
    tick();
    check("b_strobe_drop", {ENGINE_DATA_IN_VECTOR_ENABLE, DATA_OUT_SCALAR_ENABLE}, 64'd0);
    bad_g = 0;
    repeat (4) begin
      tick();
      if (GRANT !== 4'b0100 || DONE !== 4'b0) bad_g++;
    end
    check("b_grant_hold", 64'(bad_g), 64'd0);
    ENGINE_READY = 1'b1;
    tick();
    ENGINE_READY = 1'b0;
    tick();
    check("b_done", {DONE, GRANT}, 64'b0100_0000);
    tick();
    check("b_gap", {DONE, GRANT}, 64'd0);
    tick();
    check("b_next_grant", GRANT, 64'b0001);
    REQ = '0;
    DATA_IN_VECTOR_ENABLE = '0;
    DATA_IN_SCALAR_ENABLE = '0;
    tick();
    ENGINE_READY = 1'b1;
    tick();
    ENGINE_READY = 1'b0;
    tick();
    check("b_next_done", DONE, 64'b0001);

    // Asynchronous reset in the middle of client 1's stream.
    do_reset();
    REQ = 4'b0010;
    tick();
    tick();
    DATA_IN[1*DW +: DW] = 64'h55;
    DATA_IN_VECTOR_ENABLE = 4'b0010;
    ENGINE_DATA_OUT = 64'h77;
    ENGINE_DATA_OUT_VECTOR_ENABLE = 1'b1;
    tick();
    check("c_pre", {GRANT, DATA_OUT_VECTOR_ENABLE, 4'(ENGINE_DATA_IN_VECTOR_ENABLE)}, 64'h221);
    #2;
    RST = 1'b1;
    #1;
    check_all_zero("c_async");
    clear_inputs();
    REQ = 4'b1000;
    #1;
    RST = 1'b0;
    tick();
    tick();
    check("c_regrant", GRANT, 64'b1000);
    check("c_regrant_size", ENGINE_SIZE_IN, 64'd19);

`ifdef ACCELERATOR_SOFTMAX_ARBITER_TIMEOUT_EN
    // Engine never answers: abort after TIMEOUT_CYCLES of streaming.
    do_reset();
    REQ = 4'b0001;
    tick();
    tick();
    check("d_start", ENGINE_START, 64'd1);
    REQ = 4'b0011;
    bad_g = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (DONE !== 4'b0 || ERROR !== 1'b0 || GRANT !== 4'b0001) bad_g++;
    end
    check("d_wait", 64'(bad_g), 64'd0);
    tick();
    check("d_abort", {ERROR, DONE, GRANT}, 64'b1_0001_0000);
    tick();
    check("d_error_pulse", ERROR, 64'd0);
    tick();
    check("d_next_grant", GRANT, 64'b0010);
`else
    // Without the watchdog the grant is held indefinitely.
    do_reset();
    REQ = 4'b0001;
    tick();
    tick();
    bad_g = 0;
    repeat (40) begin
      tick();
      if (GRANT !== 4'b0001 || DONE !== 4'b0 || ERROR !== 1'b0) bad_g++;
    end
    check("d_no_timeout", 64'(bad_g), 64'd0);
    ENGINE_READY = 1'b1;
    tick();
    ENGINE_READY = 1'b0;
    tick();
    check("d_done", {ERROR, DONE}, 64'b0_0001);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
